// File: rtl/table_entry_parser_pkg.sv
// Shared definitions for the table-entry receive parser and its transmit-side counterpart:
// FSM state encoding and the ASCII framing characters of t[NN]="payload".
package table_entry_parser_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GOT_T,
        GOT_LB,
        GOT_D1,
        GOT_D2,
        GOT_RB,
        GOT_EQ,
        PAYLOAD
    } parser_state_t;

    localparam logic [7:0] CH_T     = 8'h74;  // 't'
    localparam logic [7:0] CH_LB    = 8'h5B;  // '['
    localparam logic [7:0] CH_RB    = 8'h5D;  // ']'
    localparam logic [7:0] CH_EQ    = 8'h3D;  // '='
    localparam logic [7:0] CH_QUOTE = 8'h22;  // '"'
    localparam logic [7:0] CH_0     = 8'h30;  // '0'
    localparam logic [7:0] CH_9     = 8'h39;  // '9'

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= CH_0) && (b <= CH_9);
    endfunction

endpackage

// File: rtl/parser_timeout.sv
// Inter-byte idle counter for table_entry_parser; flags expiry once TIMEOUT_CYCLES-1
// cycles have passed since the last clear. Only instantiated under TABLE_PARSER_TIMEOUT_EN.
module parser_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] count;

    assign expired = (count == CW'(TIMEOUT_CYCLES - 1));

    // Holds at the expiry value so it never wraps while the parser drops back to IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (!expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/table_entry_parser.sv
// Byte-stream parser for UART frames of the form t[NN]="payload", all outputs registered.
// Optional inter-byte timeout enabled with macro TABLE_PARSER_TIMEOUT_EN.
module table_entry_parser
    import table_entry_parser_pkg::*;
#(
    parameter int MAX_INDEX      = 20,
    parameter int MAX_PAYLOAD    = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rxdata,
    input  logic       rxvalid,
    output logic [4:0] arraypos,
    output logic       hdr_valid,
    output logic [7:0] payload_data,
    output logic       payload_valid,
    output logic       entry_done,
    output logic [4:0] payload_len,
    output logic       parse_err,
    output logic       busy
);

    if (MAX_INDEX < 1 || MAX_INDEX > 31 || MAX_PAYLOAD < 0 || MAX_PAYLOAD > 31 ||
        TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("table_entry_parser: parameter out of range");
    end

    parser_state_t state;
    parser_state_t hdr_next;
    logic          hdr_ok;
    logic [3:0]    d1;
    logic [4:0]    index;
    logic [4:0]    count;
    logic [6:0]    idx;
    logic          idx_ok;
    logic          timeout_hit;

    // ASCII digits occupy 0x30-0x39, so the low nibble is the digit value.
    assign idx    = {3'b000, d1} * 7'd10 + {3'b000, rxdata[3:0]};
    assign idx_ok = (idx != 7'd0) && (idx <= 7'(MAX_INDEX));

`ifdef TABLE_PARSER_TIMEOUT_EN
    logic tmo_expired;

    parser_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (rxvalid || (state == IDLE)),
        .expired(tmo_expired)
    );

    assign timeout_hit = tmo_expired && (state != IDLE);
`else
    assign timeout_hit = 1'b0;
`endif

    // Expected byte and successor for each header state.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        hdr_ok   = 1'b0;
        hdr_next = IDLE;
        case (state)
            GOT_T:   begin hdr_ok = (rxdata == CH_LB);    hdr_next = GOT_LB;  end
            GOT_LB:  begin hdr_ok = is_digit(rxdata);     hdr_next = GOT_D1;  end
            GOT_D1:  begin hdr_ok = is_digit(rxdata);     hdr_next = GOT_D2;  end
            GOT_D2:  begin hdr_ok = (rxdata == CH_RB);    hdr_next = GOT_RB;  end
            GOT_RB:  begin hdr_ok = (rxdata == CH_EQ);    hdr_next = GOT_EQ;  end
            GOT_EQ:  begin hdr_ok = (rxdata == CH_QUOTE); hdr_next = PAYLOAD; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            d1            <= '0;
            index         <= '0;
            count         <= '0;
            arraypos      <= '0;
            hdr_valid     <= 1'b0;
            payload_data  <= '0;
            payload_valid <= 1'b0;
            entry_done    <= 1'b0;
            payload_len   <= '0;
            parse_err     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            hdr_valid     <= 1'b0;
            payload_valid <= 1'b0;
            entry_done    <= 1'b0;
            parse_err     <= 1'b0;

            if (rxvalid) begin
                case (state)
                    IDLE: begin
                        if (rxdata == CH_T) begin
                            state <= GOT_T;
                            busy  <= 1'b1;
                        end
                    end
                    PAYLOAD: begin
                        if (rxdata == CH_QUOTE) begin
                            entry_done  <= 1'b1;
                            payload_len <= count;
                            state       <= IDLE;
                            busy        <= 1'b0;
                        end else if (count == 5'(MAX_PAYLOAD)) begin
                            parse_err <= 1'b1;
                            state     <= IDLE;
                            busy      <= 1'b0;
                        end else begin
                            payload_valid <= 1'b1;
                            payload_data  <= rxdata;
                            count         <= count + 1'b1;
                        end
                    end
                    default: begin
                        if (!hdr_ok) begin
                            // A stray 't' may be the start of a fresh frame, so resync on it.
                            parse_err <= 1'b1;
                            state     <= (rxdata == CH_T) ? GOT_T : IDLE;
                            busy      <= (rxdata == CH_T);
                        end else if (state == GOT_D1 && !idx_ok) begin
                            parse_err <= 1'b1;
                            state     <= IDLE;
                            busy      <= 1'b0;
                        end else begin
                            state <= hdr_next;
                            busy  <= 1'b1;
                            if (state == GOT_LB) d1 <= rxdata[3:0];
                            if (state == GOT_D1) index <= idx[4:0];
                            if (state == GOT_EQ) begin
                                arraypos  <= index;
                                hdr_valid <= 1'b1;
                                count     <= '0;
                            end
                        end
                    end
                endcase
            end else if (timeout_hit) begin
                parse_err <= 1'b1;
                state     <= IDLE;
                busy      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_table_entry_parser.sv
// Scoreboard bench for table_entry_parser; the timeout scenario runs only when
// TABLE_PARSER_TIMEOUT_EN is defined for both bench and RTL.
module tb_table_entry_parser;

    localparam int EV_HDR  = 0;
    localparam int EV_PAY  = 1;
    localparam int EV_DONE = 2;
    localparam int EV_ERR  = 3;

    typedef struct {
        int kind;
        int val;
    } evt_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rxdata = 8'h00;
    logic       rxvalid = 1'b0;
    logic [4:0] arraypos;
    logic       hdr_valid;
    logic [7:0] payload_data;
    logic       payload_valid;
    logic       entry_done;
    logic [4:0] payload_len;
    logic       parse_err;
    logic       busy;

    evt_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;

    table_entry_parser #(
        .MAX_INDEX     (20),
        .MAX_PAYLOAD   (16),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rxdata       (rxdata),
        .rxvalid      (rxvalid),
        .arraypos     (arraypos),
        .hdr_valid    (hdr_valid),
        .payload_data (payload_data),
        .payload_valid(payload_valid),
        .entry_done   (entry_done),
        .payload_len  (payload_len),
        .parse_err    (parse_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic push(input int kind, input int val);
        evt_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    // Inputs change on the falling edge; the byte is sampled on the following rising edge.
    task automatic send_byte(input logic [7:0] b);
        rxdata  = b;
        rxvalid = 1'b1;
        @(negedge clk);
        rxvalid = 1'b0;
        rxdata  = 8'h00;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic drain(input string tag);
        repeat (3) @(negedge clk);
        check({tag, "_drained"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Any output pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (mon_en) begin
            int   npulse;
            int   kind;
            int   val;
            evt_t e;
            npulse = int'(hdr_valid) + int'(payload_valid) + int'(entry_done) + int'(parse_err);
            if (npulse > 1) check("pulse_onehot", npulse, 1);
            if (npulse >= 1) begin
                if (hdr_valid)          begin kind = EV_HDR;  val = int'(arraypos);     end
                else if (payload_valid) begin kind = EV_PAY;  val = int'(payload_data); end
                else if (entry_done)    begin kind = EV_DONE; val = int'(payload_len);  end
                else                    begin kind = EV_ERR;  val = 0;                  end
                if (exp_q.size() == 0) begin
                    check("unexpected_evt", kind, -1);
                end else begin
                    e = exp_q.pop_front();
                    check("evt_kind", kind, e.kind);
                    check("evt_val", val, e.val);
                end
            end
        end
    end

    initial begin
        // Reset state, sampled while reset is still asserted.
        #12;
        check("rst_arraypos", arraypos, 0);
        check("rst_payload_data", payload_data, 0);
        check("rst_payload_len", payload_len, 0);
        check("rst_pulses", {hdr_valid, payload_valid, entry_done, parse_err}, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Basic frame with a two-byte payload.
        push(EV_HDR, 7); push(EV_PAY, 8'h41); push(EV_PAY, 8'h42); push(EV_DONE, 2);
        send_byte("t");
        check("busy_in_frame", busy, 1);
        send_str("[07]=\"AB\"");
        drain("basic");
        check("busy_after_frame", busy, 0);

        // Index above MAX_INDEX; the rest of the header is ignored in IDLE.
        push(EV_ERR, 0);
        send_str("t[21");
        check("busy_after_badidx", busy, 0);
        check("arraypos_held", arraypos, 7);
        send_str("]=\"");
        drain("bad_index");

        // Resync on a stray 't' inside the header, then an empty payload.
        push(EV_ERR, 0); push(EV_HDR, 3); push(EV_DONE, 0);
        send_str("t[1t[03]=\"\"");
        drain("resync");

        // Payload overflow on the 17th byte.
        push(EV_HDR, 5);
        for (int i = 0; i < 16; i++) push(EV_PAY, 8'h78);
        push(EV_ERR, 0);
        send_str("t[05]=\"");
        for (int i = 0; i < 17; i++) send_byte("x");
        check("busy_after_overflow", busy, 0);
        send_byte("\"");
        drain("overflow");

        // Boundaries: highest index, index zero, exactly MAX_PAYLOAD bytes.
        push(EV_HDR, 20); push(EV_DONE, 0);
        send_str("t[20]=\"\"");
        push(EV_ERR, 0);
        send_str("t[00");
        push(EV_HDR, 5);
        for (int i = 0; i < 16; i++) push(EV_PAY, 8'h78);
        push(EV_DONE, 16);
        send_str("t[05]=\"");
        for (int i = 0; i < 16; i++) send_byte("x");
        send_byte("\"");
        drain("boundary");
        check("len_before_reset", payload_len, 16);

        // Asynchronous reset mid-frame, away from any clock edge.
        send_str("t[1");
        #3;
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        check("midrst_arraypos", arraypos, 0);
        check("midrst_payload_data", payload_data, 0);
        check("midrst_payload_len", payload_len, 0);
        check("midrst_busy", busy, 0);
        @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        push(EV_HDR, 12); push(EV_PAY, 8'h5A); push(EV_DONE, 1);
        send_str("t[12]=\"Z\"");
        drain("after_reset");

`ifdef TABLE_PARSER_TIMEOUT_EN
        begin
            int n;
            push(EV_ERR, 0);
            send_str("t[");
            n = 0;
            while (n < 200) begin
                @(negedge clk);
                n++;
                if (parse_err) break;
            end
            check("timeout_latency", n, 50);
            check("busy_after_timeout", busy, 0);
            drain("timeout");

            // A byte landing on the expiry cycle is processed and suppresses the timeout.
            push(EV_HDR, 7); push(EV_DONE, 0);
            send_str("t[");
            repeat (49) @(negedge clk);
            send_str("07]=\"\"");
            drain("timeout_coincide");
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
